// File: rtl/sobel_pkg.sv
// Shared Sobel datapath constants and helpers.
//   PIX_W   : pixel width
//   SUM_W   : width of a weighted three-pixel column/row sum (max 1020)
//   DIFF_W  : width of a signed gradient (range -1020..1020)
//   MAG_MAX : saturation ceiling for the output magnitude
package sobel_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned DIFF_W = 11;
  localparam logic [PIX_W-1:0] MAG_MAX = 8'd255;

  // a + 2*b + c; the doubling is a left shift, zero-extended to SUM_W
  function automatic logic [SUM_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // |pos - neg| via an 11-bit signed difference
  function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] pos,
                                                input logic [SUM_W-1:0] neg);
    logic signed [DIFF_W-1:0] d;
    logic signed [DIFF_W-1:0] nd;
    d  = $signed({1'b0, pos}) - $signed({1'b0, neg});
    nd = -d;
    return d[DIFF_W-1] ? nd[SUM_W-1:0] : d[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_frame_tracker.sv
// Frame position tracker for the Sobel stage.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : window strobe; counters advance once per strobe
//   keep      : current strobe lies in row >= 2 (produces an output)
//   sol       : current strobe is the first output pixel of a row
//   eof       : current strobe is the last pixel of the frame
// Outputs are combinational from the counters; they describe the strobe
// presented in the current cycle.
module sobel_frame_tracker #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic keep,
  output logic sol,
  output logic eof
);

  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned ROW_W = $clog2(HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 3);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_valid) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    keep = (row_cnt >= ROW_W'(2));
    sol  = keep && (col_cnt == '0);
    eof  = (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
  end

endmodule

// File: rtl/sobel_magnitude.sv
// Three-stage Sobel gradient magnitude with edge threshold.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : one 3x3 window per high cycle
//   z1..z9     : window pixels, row-major (z5 centre)
//   thresh     : edge threshold, sampled in the output stage
//   mag        : min(|Gx|+|Gy|, 255)
//   edge_flag  : mag >= thresh (qualified by out_valid)
//   out_valid  : output pixel valid, 3 cycles after its strobe
//   out_sol    : first output pixel of a row
//   out_eof    : last output pixel of the frame
// Windows from the first two image rows are consumed but never emitted.
module sobel_magnitude
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] z1,
  input  logic [PIX_W-1:0] z2,
  input  logic [PIX_W-1:0] z3,
  input  logic [PIX_W-1:0] z4,
  input  logic [PIX_W-1:0] z5,
  input  logic [PIX_W-1:0] z6,
  input  logic [PIX_W-1:0] z7,
  input  logic [PIX_W-1:0] z8,
  input  logic [PIX_W-1:0] z9,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] mag,
  output logic             edge_flag,
  output logic             out_valid,
  output logic             out_sol,
  output logic             out_eof
);

  logic trk_keep, trk_sol, trk_eof;

  sobel_frame_tracker #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .keep    (trk_keep),
    .sol     (trk_sol),
    .eof     (trk_eof)
  );

  // Stage 1: weighted column/row sums and position tags
  logic [SUM_W-1:0] s1_p, s1_n, s1_q, s1_r;
  logic             s1_valid, s1_sol, s1_eof;

  // Stage 2: absolute gradients
  logic [SUM_W-1:0] s2_ax, s2_ay;
  logic             s2_valid, s2_sol, s2_eof;

  // Stage 3 combinational saturation
  logic [SUM_W:0]   mag_sum;
  logic [PIX_W-1:0] mag_next;

  // z5 carries no weight in either kernel
  logic unused_centre;
  assign unused_centre = ^z5;

  always_comb begin
    mag_sum  = {1'b0, s2_ax} + {1'b0, s2_ay};
    mag_next = (mag_sum > (SUM_W+1)'(MAG_MAX)) ? MAG_MAX : mag_sum[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    s1_p <= wsum(z3, z6, z9);
    s1_n <= wsum(z1, z4, z7);
    s1_q <= wsum(z7, z8, z9);
    s1_r <= wsum(z1, z2, z3);
    s2_ax <= abs_diff(s1_p, s1_n);
    s2_ay <= abs_diff(s1_q, s1_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sol    <= 1'b0;
      s1_eof    <= 1'b0;
      s2_valid  <= 1'b0;
      s2_sol    <= 1'b0;
      s2_eof    <= 1'b0;
      mag       <= '0;
      edge_flag <= 1'b0;
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      s1_valid  <= in_valid && trk_keep;
      s1_sol    <= in_valid && trk_sol;
      s1_eof    <= in_valid && trk_eof;
      s2_valid  <= s1_valid;
      s2_sol    <= s1_sol;
      s2_eof    <= s1_eof;
      mag       <= mag_next;
      edge_flag <= s2_valid && (mag_next >= thresh);
      out_valid <= s2_valid;
      out_sol   <= s2_sol;
      out_eof   <= s2_eof;
    end
  end

endmodule

// File: tb/tb_sobel_magnitude.sv
// Self-checking bench for sobel_magnitude: directed windows, continuous and
// gapped frames, and a mid-frame reset, against a strobe-count reference model.
module tb_sobel_magnitude;

  localparam int W         = 8;
  localparam int H         = 8;
  localparam int PER_ROW   = W - 2;
  localparam int PER_FRAME = PER_ROW * H;
  localparam int OUT_FRAME = (H - 2) * (W - 2);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] zr [1:9];
  logic [7:0] thresh = 8'd0;
  logic [7:0] mag;
  logic       edge_flag, out_valid, out_sol, out_eof;

  typedef struct {
    bit valid;
    bit sol;
    bit eof;
    int mag;
  } exp_t;

  exp_t pipe [3];
  int   idx      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   strobes  = 0;

  always #5 clk = ~clk;

  sobel_magnitude #(
    .WIDTH (W),
    .HEIGHT(H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .z1       (zr[1]),
    .z2       (zr[2]),
    .z3       (zr[3]),
    .z4       (zr[4]),
    .z5       (zr[5]),
    .z6       (zr[6]),
    .z7       (zr[7]),
    .z8       (zr[8]),
    .z9       (zr[9]),
    .thresh   (thresh),
    .mag      (mag),
    .edge_flag(edge_flag),
    .out_valid(out_valid),
    .out_sol  (out_sol),
    .out_eof  (out_eof)
  );

  function automatic int ref_mag();
    int gx, gy, s;
    gx = (int'(zr[3]) + 2*int'(zr[6]) + int'(zr[9])) - (int'(zr[1]) + 2*int'(zr[4]) + int'(zr[7]));
    gy = (int'(zr[7]) + 2*int'(zr[8]) + int'(zr[9])) - (int'(zr[1]) + 2*int'(zr[2]) + int'(zr[3]));
    s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 255 : s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic rand_window();
    for (int i = 1; i <= 9; i++) zr[i] = 8'($urandom);
  endtask

  // One clock: drive inputs, advance the model, compare the output stage.
  task automatic step(input bit v);
    exp_t e;
    int row, col;
    e = '{valid: 1'b0, sol: 1'b0, eof: 1'b0, mag: 0};
    in_valid = v;
    if (!rst && v) begin
      row     = idx / PER_ROW;
      col     = idx % PER_ROW;
      e.valid = (row >= 2);
      e.sol   = e.valid && (col == 0);
      e.eof   = e.valid && (col == PER_ROW - 1) && (row == H - 1);
      e.mag   = ref_mag();
      idx     = (idx + 1) % PER_FRAME;
    end
    @(posedge clk);
    #1;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{valid: 1'b0, sol: 1'b0, eof: 1'b0, mag: 0};
      idx = 0;
      check("rst_mag", 32'(mag), 0);
    end
    check("out_valid", 32'(out_valid), 32'(pipe[2].valid));
    check("out_sol",   32'(out_sol),   32'(pipe[2].sol));
    check("out_eof",   32'(out_eof),   32'(pipe[2].eof));
    check("edge",      32'(edge_flag), 32'(pipe[2].valid && (pipe[2].mag >= int'(thresh))));
    if (pipe[2].valid) check("mag", 32'(mag), 32'(pipe[2].mag));
    if (out_valid === 1'b1) n_out++;
    if (v) strobes++;
  endtask

  // One directed window followed by two bubbles; its result is visible then.
  task automatic directed(input string tag, input logic [71:0] win, input logic [7:0] th,
                          input int exp_mag, input bit exp_edge);
    thresh = th;
    for (int i = 1; i <= 9; i++) zr[i] = win[(9-i)*8 +: 8];
    step(1'b1);
    rand_window();
    step(1'b0);
    step(1'b0);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_mag"},   32'(mag), 32'(exp_mag));
    check({tag, "_edge"},  32'(edge_flag), 32'(exp_edge));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '{valid: 1'b0, sol: 1'b0, eof: 1'b0, mag: 0};
    rand_window();

    // reset state
    rst = 1'b1;
    step(1'b0);
    step(1'b1);
    rst = 1'b0;

    // frame 1: suppressed rows, then directed windows, then random fill
    n_out  = 0;
    thresh = 8'd128;
    for (int i = 0; i < 12; i++) begin rand_window(); step(1'b1); end
    check("rows01_suppressed", 32'(n_out), 0);
    directed("vstep",     {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255}, 8'd128, 255, 1'b1);
    directed("flat_t1",   {9{8'd100}}, 8'd1, 0, 1'b0);
    directed("flat_t0",   {9{8'd100}}, 8'd0, 0, 1'b1);
    directed("grad_t40",  {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10}, 8'd40, 40, 1'b1);
    directed("grad_t41",  {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10}, 8'd41, 40, 1'b0);
    directed("diag",      {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255}, 8'd128, 255, 1'b1);
    directed("diag_t255", {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255}, 8'd255, 255, 1'b1);
    for (int i = 0; i < 29; i++) begin
      rand_window();
      thresh = 8'($urandom);
      step(1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b0);
    check("frame1_count", 32'(n_out), 32'(OUT_FRAME));

    // two back-to-back frames with no idle cycle
    n_out = 0;
    for (int i = 0; i < 2 * PER_FRAME; i++) begin
      rand_window();
      if (i % 16 == 0) thresh = 8'($urandom);
      step(1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b0);
    check("frame23_count", 32'(n_out), 32'(2 * OUT_FRAME));

    // gapped strobes up to mid-row 4, then reset
    for (int c = 0; idx != 4 * PER_ROW + 3 && c < 2000; c++) begin
      rand_window();
      step(1'($urandom_range(0, 1)));
    end
    check("reached_row4", 32'(idx), 32'(4 * PER_ROW + 3));
    rst = 1'b1;
    rand_window();
    step(1'b1);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_edge", 32'(edge_flag), 0);

    // fresh frame with random gaps
    n_out   = 0;
    strobes = 0;
    for (int c = 0; strobes < PER_FRAME && c < 2000; c++) begin
      rand_window();
      if ($urandom_range(0, 7) == 0) thresh = 8'($urandom);
      step(1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0);
    check("gapped_frame_count", 32'(n_out), 32'(OUT_FRAME));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
